lpe_array_scheduler: RTL and testbench
======================================

Name: lpe_array_scheduler

Overview:
- Sequences one layer pass through a row of PE_NUMBER linear processing elements.
- Accepts a layer descriptor (input length, output-neuron count) and splits the output neurons into tiles of PE_NUMBER.
- For each tile, joins the upstream data and weight streams beat-for-beat into the PE array and marks the last beat of the tile.
- Counts returned PE results and signals completion; sits between the layer DMA/stream sources and the PE row.

Parameters:
PE_NUMBER, 8, PEs per array; maximum neurons per tile
DATA_WIDTH_DATA, 16, data beat width
DATA_WIDTH_WEIGHT, 16, per-PE weight width; the weight beat is PE_NUMBER*DATA_WIDTH_WEIGHT
LEN_WIDTH, 16, width of length/count fields
DEST_WIDTH, 8, tdest width; carries the tile index, truncated
USER_WIDTH, 8, tuser width; carries active PE count minus 1; must be >= clog2(PE_NUMBER)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
s_cfg_in_len  in  LEN_WIDTH  input features per neuron
s_cfg_out_len  in  LEN_WIDTH  output neurons in layer
s_cfg_valid  in  1  descriptor valid
s_cfg_ready  out  1  descriptor accepted
s_axis_data_tdata  in  DATA_WIDTH_DATA  feature beat
s_axis_data_tvalid  in  1  AXIS valid
s_axis_data_tready  out  1  AXIS ready
s_axis_weight_tdata  in  PE_NUMBER*DATA_WIDTH_WEIGHT  weight beat, PE i in slice i
s_axis_weight_tvalid  in  1  AXIS valid
s_axis_weight_tready  out  1  AXIS ready
m_axis_pe_data_tdata  out  DATA_WIDTH_DATA  broadcast feature to PEs
m_axis_pe_weight_tdata  out  PE_NUMBER*DATA_WIDTH_WEIGHT  weights to PEs
m_axis_pe_tvalid  out  1  joined beat valid
m_axis_pe_tready  in  1  PE row ready
m_axis_pe_tlast  out  1  last feature of tile
m_axis_pe_tdest  out  DEST_WIDTH  tile index
m_axis_pe_tuser  out  USER_WIDTH  active PEs in tile minus 1
rslt_beat  in  1  one PE result handshake completed (valid & ready on the collector)
busy  out  1  descriptor in progress
done  out  1  one-cycle pulse at end of layer
cfg_err  out  1  one-cycle pulse: zero-length descriptor

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All counters 0. busy, done, cfg_err, m_axis_pe_tvalid, s_axis_*_tready are 0. s_cfg_ready is 1.
- FSM states: IDLE, RUN, WAIT_RSLT, DONE.
- IDLE:
  - s_cfg_ready=1.
  - On cfg handshake, latch in_len and out_len.
  - Compute tiles=ceil(out_len/PE_NUMBER); last_active=out_len-(tiles-1)*PE_NUMBER.
  - If in_len==0 or out_len==0: go to DONE and pulse cfg_err with done in the same cycle.
  - Otherwise go to RUN with tile=0 and beat=0.
- RUN:
  - Output register stage is a 1-deep skid buffer; throughput is 1 beat/cycle.
  - Upstream join: s_axis_data_tready = s_axis_weight_tready = (both tvalid) & skid-free & beat<in_len.
  - Neither input stream is consumed alone.
  - Registered beat: tlast=(beat==in_len-1), tdest=tile[DEST_WIDTH-1:0], tuser=active-1, where active=PE_NUMBER except last_active on the final tile.
  - Weight slices for inactive PEs are forced to 0.
  - When the last beat is accepted by the PE row, go to WAIT_RSLT.
- WAIT_RSLT:
  - Count rslt_beat pulses; rslt_beat pulses during RUN also count.
  - When count==active: clear the count, then tile++ → RUN, or DONE if this was the last tile.
  - Extra rslt_beat beyond active is ignored.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, WAIT_RSLT and DONE.
- Latency: cfg accept → first possible input handshake is 1 cycle; input handshake → m_axis_pe_tvalid is 1 cycle.
- Backpressure: m_axis_pe_tvalid holds and its payload stays stable until tready.
- Upstream sends the full feature vector again for every tile; the scheduler does not buffer features.
- s_cfg_valid while busy is not accepted (s_cfg_ready=0).
- Counters are LEN_WIDTH wide; in_len=2^LEN_WIDTH-1 is supported without overflow.

Optional Feature:
LPE_SCHED_PERF_CNT_EN:
- Defined: adds outputs perf_cycles and perf_stalls, both 32 bits.
  - perf_cycles counts cycles with busy=1.
  - perf_stalls counts cycles in RUN with m_axis_pe_tvalid & !m_axis_pe_tready.
  - Both clear on cfg accept, saturate at max, and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package lpe_pkg holds:
  - state enum (IDLE/RUN/WAIT_RSLT/DONE)
  - localparam function clog2-based widths
  - tile-count helper function ceil_div
- One sub-module: lpe_axis_join_skid, a 2-input join plus 1-deep skid register, parameterised on payload width.

Test Plan:
- in_len=4, out_len=8, PE_NUMBER=8, no backpressure → 4 beats, tlast on 4th, tdest=0, tuser=7; 8 rslt_beat → done pulse, busy falls next cycle.
- in_len=3, out_len=10 → tile0 tuser=7, tile1 tuser=1 with weight slices 2..7 zero; tdest 0 then 1; done only after 8+2 results.
- Data valid every cycle, weight valid every other cycle → both readys assert only on joint cycles; exactly in_len beats delivered, no duplicates or drops.
- m_axis_pe_tready toggling 1010 mid-tile → payload stable while stalled; beat order preserved; the PERF macro build reports matching stall count.
- out_len=0 → cfg_err and done pulse together 1 cycle after accept; no stream handshakes.
- rst asserted during RUN with tvalid high → all outputs to reset values immediately; next descriptor runs cleanly from tile 0.

Source files
------------

// File: rtl/lpe_pkg.sv
// ---------------------------------------------------------------------------
// lpe_pkg
// Shared definitions for the linear-PE array scheduler:
//   - FSM state encodings (IDLE / RUN / WAIT_RSLT / DONE)
//   - act_width(): width needed to hold an active-PE count 0..PE_NUMBER
//   - ceil_div():  tile-count helper, ceil(num / den)
// ---------------------------------------------------------------------------
package lpe_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_WAIT_RSLT = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    // Bits needed to count 0..pe_number inclusive.
    function automatic int act_width(input int pe_number);
        return $clog2(pe_number + 1);
    endfunction

    // Evaluated at 32 bits so a full-scale LEN_WIDTH operand cannot wrap.
    function automatic logic [31:0] ceil_div(input logic [31:0] num,
                                             input logic [31:0] den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/lpe_axis_join_skid.sv
// ---------------------------------------------------------------------------
// lpe_axis_join_skid
// Joins two valid/ready streams into one and registers the result through a
// 1-deep skid buffer, so the upstream ready never depends on i_ready and the
// path sustains one beat per cycle.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_a_valid, i_b_valid valids of the two joined streams
//   i_en                 join permitted this cycle
//   o_ready              shared ready returned to both streams
//   i_payload            combined payload sampled on the join handshake
//   o_valid, o_payload   registered output beat
//   i_ready              downstream ready
// ---------------------------------------------------------------------------
module lpe_axis_join_skid #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_a_valid,
    input  logic                 i_b_valid,
    input  logic                 i_en,
    output logic                 o_ready,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_valid,
    output logic [PAYLOAD_W-1:0] o_payload,
    input  logic                 i_ready
);

    logic                 r_out_valid;
    logic [PAYLOAD_W-1:0] r_out_data;
    logic                 r_skid_valid;
    logic [PAYLOAD_W-1:0] r_skid_data;
    logic                 w_out_free;

    // Both streams move together, and only while the skid slot is empty.
    assign o_ready    = i_a_valid & i_b_valid & i_en & ~r_skid_valid;
    assign w_out_free = ~r_out_valid | i_ready;
    assign o_valid    = r_out_valid;
    assign o_payload  = r_out_data;

    // Output register refill: skid contents first, then a fresh join beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= {PAYLOAD_W{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_data  <= {PAYLOAD_W{1'b0}};
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (o_ready) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= i_payload;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (o_ready) begin
            // Output stalled: park the accepted beat in the skid slot.
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_payload;
        end else begin
            r_skid_valid <= r_skid_valid;
        end
    end

endmodule

// File: rtl/lpe_array_scheduler.sv
// ---------------------------------------------------------------------------
// lpe_array_scheduler
// Runs one layer pass through a row of PE_NUMBER linear PEs. A descriptor
// (in_len features, out_len neurons) is split into ceil(out_len/PE_NUMBER)
// tiles; for every tile the data and weight streams are joined beat-for-beat
// into the PE row (tlast on the final feature, tdest = tile index, tuser =
// active PEs - 1), then the scheduler waits for one result per active PE.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   s_cfg_*                  layer descriptor handshake
//   s_axis_data_*            feature stream (broadcast to all PEs)
//   s_axis_weight_*          weight stream, PE i in slice i
//   m_axis_pe_*              joined, registered stream to the PE row
//   rslt_beat                one PE result handshake completed
//   busy, done, cfg_err      status; done/cfg_err are one-cycle pulses
// Optional build macro LPE_SCHED_PERF_CNT_EN adds perf_cycles / perf_stalls.
// ---------------------------------------------------------------------------
module lpe_array_scheduler
    import lpe_pkg::*;
#(
    parameter int PE_NUMBER         = 8,
    parameter int DATA_WIDTH_DATA   = 16,
    parameter int DATA_WIDTH_WEIGHT = 16,
    parameter int LEN_WIDTH         = 16,
    parameter int DEST_WIDTH        = 8,
    parameter int USER_WIDTH        = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [LEN_WIDTH-1:0]                   s_cfg_in_len,
    input  logic [LEN_WIDTH-1:0]                   s_cfg_out_len,
    input  logic                                   s_cfg_valid,
    output logic                                   s_cfg_ready,
    input  logic [DATA_WIDTH_DATA-1:0]             s_axis_data_tdata,
    input  logic                                   s_axis_data_tvalid,
    output logic                                   s_axis_data_tready,
    input  logic [PE_NUMBER*DATA_WIDTH_WEIGHT-1:0] s_axis_weight_tdata,
    input  logic                                   s_axis_weight_tvalid,
    output logic                                   s_axis_weight_tready,
    output logic [DATA_WIDTH_DATA-1:0]             m_axis_pe_data_tdata,
    output logic [PE_NUMBER*DATA_WIDTH_WEIGHT-1:0] m_axis_pe_weight_tdata,
    output logic                                   m_axis_pe_tvalid,
    input  logic                                   m_axis_pe_tready,
    output logic                                   m_axis_pe_tlast,
    output logic [DEST_WIDTH-1:0]                  m_axis_pe_tdest,
    output logic [USER_WIDTH-1:0]                  m_axis_pe_tuser,
    input  logic                                   rslt_beat,
`ifdef LPE_SCHED_PERF_CNT_EN
    output logic [31:0]                            perf_cycles,
    output logic [31:0]                            perf_stalls,
`endif
    output logic                                   busy,
    output logic                                   done,
    output logic                                   cfg_err
);

    localparam int ACT_W     = act_width(PE_NUMBER);
    localparam int WGT_W     = PE_NUMBER * DATA_WIDTH_WEIGHT;
    localparam int PAYLOAD_W = DATA_WIDTH_DATA + WGT_W + 1 + DEST_WIDTH + USER_WIDTH;

    logic [1:0]           r_state;
    logic [LEN_WIDTH-1:0] r_in_len;
    logic [LEN_WIDTH-1:0] r_tiles;
    logic [LEN_WIDTH-1:0] r_tile;
    logic [LEN_WIDTH-1:0] r_beat;
    logic [ACT_W-1:0]     r_last_active;
    logic [ACT_W-1:0]     r_rslt_cnt;
    logic                 r_cfg_err;

    logic                 w_cfg_fire;
    logic                 w_cfg_zero;
    logic [LEN_WIDTH-1:0] w_tiles;
    logic [ACT_W-1:0]     w_last_active;
    logic                 w_last_tile;
    logic [ACT_W-1:0]     w_active;
    logic                 w_join_en;
    logic                 w_join_ready;
    logic                 w_beat_last;
    logic [WGT_W-1:0]     w_wgt_masked;
    logic [PAYLOAD_W-1:0] w_in_payload;
    logic [PAYLOAD_W-1:0] w_out_payload;
    logic                 w_out_last_fire;

    assign w_cfg_fire    = s_cfg_valid & s_cfg_ready;
    assign w_cfg_zero    = (s_cfg_in_len == {LEN_WIDTH{1'b0}}) |
                           (s_cfg_out_len == {LEN_WIDTH{1'b0}});
    assign w_tiles       = LEN_WIDTH'(ceil_div(32'(s_cfg_out_len), 32'(PE_NUMBER)));
    // Neurons left for the final tile: 1..PE_NUMBER for any non-zero out_len.
    assign w_last_active = ACT_W'(32'(s_cfg_out_len) -
                                  (32'(w_tiles) - 32'd1) * 32'(PE_NUMBER));

    assign w_last_tile   = (r_tile == (r_tiles - LEN_WIDTH'(1)));
    assign w_active      = w_last_tile ? r_last_active : ACT_W'(PE_NUMBER);
    // beat < in_len keeps the counter within LEN_WIDTH even at in_len = max.
    assign w_join_en     = (r_state == ST_RUN) & (r_beat < r_in_len);
    assign w_beat_last   = (r_beat == (r_in_len - LEN_WIDTH'(1)));

    // Zero the weight slices of PEs that have no neuron in this tile.
    for (genvar gi = 0; gi < PE_NUMBER; gi++) begin : g_wmask
        assign w_wgt_masked[gi*DATA_WIDTH_WEIGHT +: DATA_WIDTH_WEIGHT] =
            (ACT_W'(gi) < w_active) ?
                s_axis_weight_tdata[gi*DATA_WIDTH_WEIGHT +: DATA_WIDTH_WEIGHT] :
                {DATA_WIDTH_WEIGHT{1'b0}};
    end

    assign w_in_payload = {s_axis_data_tdata,
                           w_wgt_masked,
                           w_beat_last,
                           DEST_WIDTH'(r_tile),
                           USER_WIDTH'(w_active - ACT_W'(1))};

    lpe_axis_join_skid #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_join (
        .clk       (clk),
        .rst_n     (rst),
        .i_a_valid (s_axis_data_tvalid),
        .i_b_valid (s_axis_weight_tvalid),
        .i_en      (w_join_en),
        .o_ready   (w_join_ready),
        .i_payload (w_in_payload),
        .o_valid   (m_axis_pe_tvalid),
        .o_payload (w_out_payload),
        .i_ready   (m_axis_pe_tready)
    );

    assign {m_axis_pe_data_tdata,
            m_axis_pe_weight_tdata,
            m_axis_pe_tlast,
            m_axis_pe_tdest,
            m_axis_pe_tuser} = w_out_payload;

    assign s_axis_data_tready   = w_join_ready;
    assign s_axis_weight_tready = w_join_ready;
    assign w_out_last_fire      = m_axis_pe_tvalid & m_axis_pe_tready & m_axis_pe_tlast;

    assign s_cfg_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign cfg_err     = r_cfg_err;

    // Layer FSM with descriptor latches and tile / beat / result counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_in_len      <= {LEN_WIDTH{1'b0}};
            r_tiles       <= {LEN_WIDTH{1'b0}};
            r_tile        <= {LEN_WIDTH{1'b0}};
            r_beat        <= {LEN_WIDTH{1'b0}};
            r_last_active <= {ACT_W{1'b0}};
            r_rslt_cnt    <= {ACT_W{1'b0}};
            r_cfg_err     <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_fire) begin
                        r_in_len      <= s_cfg_in_len;
                        r_tiles       <= w_tiles;
                        r_last_active <= w_last_active;
                        r_tile        <= {LEN_WIDTH{1'b0}};
                        r_beat        <= {LEN_WIDTH{1'b0}};
                        r_rslt_cnt    <= {ACT_W{1'b0}};
                        if (w_cfg_zero) begin
                            r_state   <= ST_DONE;
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_state   <= ST_RUN;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (w_join_ready) begin
                        r_beat <= r_beat + LEN_WIDTH'(1);
                    end else begin
                        r_beat <= r_beat;
                    end
                    // Fast PEs may report before the tile's last beat leaves.
                    if (rslt_beat && (r_rslt_cnt < w_active)) begin
                        r_rslt_cnt <= r_rslt_cnt + ACT_W'(1);
                    end else begin
                        r_rslt_cnt <= r_rslt_cnt;
                    end
                    if (w_out_last_fire) begin
                        r_state <= ST_WAIT_RSLT;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_WAIT_RSLT: begin
                    if (r_rslt_cnt == w_active) begin
                        r_rslt_cnt <= {ACT_W{1'b0}};
                        r_beat     <= {LEN_WIDTH{1'b0}};
                        if (w_last_tile) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_tile  <= r_tile + LEN_WIDTH'(1);
                            r_state <= ST_RUN;
                        end
                    end else if (rslt_beat) begin
                        r_rslt_cnt <= r_rslt_cnt + ACT_W'(1);
                    end else begin
                        r_rslt_cnt <= r_rslt_cnt;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LPE_SCHED_PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;

    // Saturating busy-cycle and output-stall counters, cleared per descriptor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_cycles <= 32'd0;
            r_perf_stalls <= 32'd0;
        end else if (w_cfg_fire) begin
            r_perf_cycles <= 32'd0;
            r_perf_stalls <= 32'd0;
        end else begin
            if (busy && (r_perf_cycles != 32'hFFFF_FFFF)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end else begin
                r_perf_cycles <= r_perf_cycles;
            end
            if ((r_state == ST_RUN) && m_axis_pe_tvalid && !m_axis_pe_tready &&
                (r_perf_stalls != 32'hFFFF_FFFF)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end else begin
                r_perf_stalls <= r_perf_stalls;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lpe_array_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lpe_array_scheduler
// Table of layer descriptors with their expected tile structure. Each entry
// is run with a bench-side data/weight source; every accepted input beat
// pushes its expected PE-side beat onto a scoreboard queue, popped and
// compared when the PE row accepts a beat. A result responder returns one
// rslt_beat per active PE after each tile's last beat.
// ---------------------------------------------------------------------------
module tb_lpe_array_scheduler;

    localparam int PE  = 8;
    localparam int DW  = 16;
    localparam int WW  = 16;
    localparam int LW  = 16;
    localparam int DSW = 8;
    localparam int UW  = 8;
    localparam int WBW = PE * WW;

    logic           clk = 1'b0;
    logic           rst;
    logic [LW-1:0]  s_cfg_in_len;
    logic [LW-1:0]  s_cfg_out_len;
    logic           s_cfg_valid;
    logic           s_cfg_ready;
    logic [DW-1:0]  s_axis_data_tdata;
    logic           s_axis_data_tvalid;
    logic           s_axis_data_tready;
    logic [WBW-1:0] s_axis_weight_tdata;
    logic           s_axis_weight_tvalid;
    logic           s_axis_weight_tready;
    logic [DW-1:0]  m_axis_pe_data_tdata;
    logic [WBW-1:0] m_axis_pe_weight_tdata;
    logic           m_axis_pe_tvalid;
    logic           m_axis_pe_tready;
    logic           m_axis_pe_tlast;
    logic [DSW-1:0] m_axis_pe_tdest;
    logic [UW-1:0]  m_axis_pe_tuser;
    logic           rslt_beat;
    logic           busy;
    logic           done;
    logic           cfg_err;
`ifdef LPE_SCHED_PERF_CNT_EN
    logic [31:0]    perf_cycles;
    logic [31:0]    perf_stalls;
`endif

    always #5 clk = ~clk;

    lpe_array_scheduler #(
        .PE_NUMBER(PE), .DATA_WIDTH_DATA(DW), .DATA_WIDTH_WEIGHT(WW),
        .LEN_WIDTH(LW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_cfg_in_len           (s_cfg_in_len),
        .s_cfg_out_len          (s_cfg_out_len),
        .s_cfg_valid            (s_cfg_valid),
        .s_cfg_ready            (s_cfg_ready),
        .s_axis_data_tdata      (s_axis_data_tdata),
        .s_axis_data_tvalid     (s_axis_data_tvalid),
        .s_axis_data_tready     (s_axis_data_tready),
        .s_axis_weight_tdata    (s_axis_weight_tdata),
        .s_axis_weight_tvalid   (s_axis_weight_tvalid),
        .s_axis_weight_tready   (s_axis_weight_tready),
        .m_axis_pe_data_tdata   (m_axis_pe_data_tdata),
        .m_axis_pe_weight_tdata (m_axis_pe_weight_tdata),
        .m_axis_pe_tvalid       (m_axis_pe_tvalid),
        .m_axis_pe_tready       (m_axis_pe_tready),
        .m_axis_pe_tlast        (m_axis_pe_tlast),
        .m_axis_pe_tdest        (m_axis_pe_tdest),
        .m_axis_pe_tuser        (m_axis_pe_tuser),
        .rslt_beat              (rslt_beat),
`ifdef LPE_SCHED_PERF_CNT_EN
        .perf_cycles            (perf_cycles),
        .perf_stalls            (perf_stalls),
`endif
        .busy                   (busy),
        .done                   (done),
        .cfg_err                (cfg_err)
    );

    typedef struct {
        logic [DW-1:0]  data;
        logic [WBW-1:0] wgt;
        logic           last;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    // Inputs: in_len, out_len, weight-valid mode, backpressure mode.
    // Expected: cfg_err, tile count, tuser of the final tile.
    typedef struct {
        int in_len;
        int out_len;
        int wmode;
        int bpmode;
        bit exp_err;
        int exp_tiles;
        int exp_last_user;
    } vec_t;

    beat_t sb_q[$];
    vec_t  vecs[8];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] gen_data(input int vi, input int t, input int b);
        return DW'(vi * 4096 + t * 256 + b + 1);
    endfunction

    function automatic logic [WBW-1:0] gen_wgt(input int t, input int b);
        logic [WBW-1:0] w;
        for (int i = 0; i < PE; i++) w[i*WW +: WW] = WW'(i * 4369 + t * 256 + b + 257);
        return w;
    endfunction

    function automatic logic [WBW-1:0] mask_wgt(input logic [WBW-1:0] w, input int act);
        logic [WBW-1:0] m;
        m = w;
        for (int i = 0; i < PE; i++) if (i >= act) m[i*WW +: WW] = {WW{1'b0}};
        return m;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cfg_ready"}, 192'(s_cfg_ready), 192'(1));
        chk({tag, "_busy"},      192'(busy), 192'(0));
        chk({tag, "_done"},      192'(done), 192'(0));
        chk({tag, "_cfg_err"},   192'(cfg_err), 192'(0));
        chk({tag, "_tvalid"},    192'(m_axis_pe_tvalid), 192'(0));
        chk({tag, "_dready"},    192'(s_axis_data_tready), 192'(0));
        chk({tag, "_wready"},    192'(s_axis_weight_tready), 192'(0));
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int    src_tile = 0;
        int    src_beat = 0;
        int    cyc = 0;
        int    pending = 0;
        int    rslt_sent = 0;
        int    tiles_seen = 0;
        int    bench_stalls = 0;
        int    act;
        bit    got_done = 0;
        bit    prev_stall = 0;
        logic [160:0] prev_pl;
        logic [160:0] cur_pl;
        beat_t e;
        beat_t g;

        sb_q.delete();
        @(negedge clk);
        s_cfg_in_len  = LW'(v.in_len);
        s_cfg_out_len = LW'(v.out_len);
        s_cfg_valid   = 1'b1;
        #1;
        chk("cfg_ready_idle", 192'(s_cfg_ready), 192'(1));
        @(negedge clk);
        s_cfg_valid = 1'b0;

        while (!got_done && cyc < 3000) begin
            case (v.bpmode)
                0:       m_axis_pe_tready = 1'b1;
                1:       m_axis_pe_tready = (cyc % 2 == 0);
                default: m_axis_pe_tready = 1'($urandom_range(0, 1));
            endcase
            rslt_beat = (pending > 0);
            if (pending > 0) begin
                pending--;
                rslt_sent++;
            end
            s_axis_data_tvalid   = 1'b1;
            s_axis_weight_tvalid = (v.wmode == 0) || (cyc % 2 == 0);
            if (src_tile < v.exp_tiles) begin
                s_axis_data_tdata   = gen_data(vi, src_tile, src_beat);
                s_axis_weight_tdata = gen_wgt(src_tile, src_beat);
            end else begin
                s_axis_data_tdata   = 16'hdead;
                s_axis_weight_tdata = {8{16'hbeef}};
            end
            #1;
            cur_pl = {m_axis_pe_data_tdata, m_axis_pe_weight_tdata, m_axis_pe_tlast,
                      m_axis_pe_tdest, m_axis_pe_tuser};
            if (prev_stall) begin
                chk("stall_tvalid_held", 192'(m_axis_pe_tvalid), 192'(1));
                chk("stall_payload_stable", 192'(cur_pl), 192'(prev_pl));
            end
            if (m_axis_pe_tvalid && m_axis_pe_tready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_beat", 192'(1), 192'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", 192'(m_axis_pe_data_tdata), 192'(e.data));
                    chk("out_wgt",  192'(m_axis_pe_weight_tdata), 192'(e.wgt));
                    chk("out_last", 192'(m_axis_pe_tlast), 192'(e.last));
                    chk("out_dest", 192'(m_axis_pe_tdest), 192'(e.dest));
                    chk("out_user", 192'(m_axis_pe_tuser), 192'(e.user));
                    if (e.last) begin
                        tiles_seen++;
                        pending += int'(e.user) + 1;
                    end
                end
            end
            prev_stall = m_axis_pe_tvalid && !m_axis_pe_tready;
            prev_pl    = cur_pl;
            if (prev_stall) bench_stalls++;
            if (s_axis_data_tready || s_axis_weight_tready) begin
                chk("join_readys_equal", 192'({s_axis_data_tready, s_axis_weight_tready}), 192'(2'b11));
                chk("join_both_valid", 192'(s_axis_data_tvalid && s_axis_weight_tvalid), 192'(1));
                if (src_tile >= v.exp_tiles) begin
                    chk("unexpected_accept", 192'(1), 192'(0));
                end else begin
                    act    = (src_tile == v.exp_tiles - 1) ? v.exp_last_user + 1 : PE;
                    g.data = gen_data(vi, src_tile, src_beat);
                    g.wgt  = mask_wgt(gen_wgt(src_tile, src_beat), act);
                    g.last = (src_beat == v.in_len - 1);
                    g.dest = DSW'(src_tile);
                    g.user = UW'(act - 1);
                    sb_q.push_back(g);
                    src_beat++;
                    if (src_beat == v.in_len) begin
                        src_beat = 0;
                        src_tile++;
                    end
                end
            end
            if (cfg_err && !done) chk("cfg_err_without_done", 192'(1), 192'(0));
            if (done) begin
                got_done = 1;
                chk("done_cfg_err", 192'(cfg_err), 192'(v.exp_err));
                chk("done_busy", 192'(busy), 192'(1));
                chk("done_results", 192'(rslt_sent), 192'(v.out_len > 0 && v.in_len > 0 ? v.out_len : 0));
                chk("done_tiles", 192'(tiles_seen), 192'(v.exp_tiles));
                chk("done_sb_empty", 192'(sb_q.size()), 192'(0));
                if (v.exp_err) chk("err_done_latency", 192'(cyc), 192'(0));
`ifdef LPE_SCHED_PERF_CNT_EN
                chk("perf_stalls", 192'(perf_stalls), 192'(bench_stalls));
                chk("perf_cycles", 192'(perf_cycles), 192'(cyc));
`endif
            end
            @(negedge clk);
            cyc++;
        end
        rslt_beat          = 1'b0;
        m_axis_pe_tready   = 1'b1;
        if (!got_done) begin
            chk("done_timeout", 192'(0), 192'(1));
            rst = 1'b0;
            #1 rst = 1'b1;
            @(negedge clk);
        end
        #1;
        check_idle_outputs("after_done");
        s_axis_data_tvalid   = 1'b0;
        s_axis_weight_tvalid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{in_len: 4, out_len: 8,  wmode: 0, bpmode: 0, exp_err: 0, exp_tiles: 1, exp_last_user: 7};
        vecs[1] = '{in_len: 3, out_len: 10, wmode: 0, bpmode: 0, exp_err: 0, exp_tiles: 2, exp_last_user: 1};
        vecs[2] = '{in_len: 5, out_len: 3,  wmode: 1, bpmode: 0, exp_err: 0, exp_tiles: 1, exp_last_user: 2};
        vecs[3] = '{in_len: 6, out_len: 16, wmode: 0, bpmode: 1, exp_err: 0, exp_tiles: 2, exp_last_user: 7};
        vecs[4] = '{in_len: 4, out_len: 0,  wmode: 0, bpmode: 0, exp_err: 1, exp_tiles: 0, exp_last_user: 0};
        vecs[5] = '{in_len: 0, out_len: 5,  wmode: 0, bpmode: 0, exp_err: 1, exp_tiles: 0, exp_last_user: 0};
        vecs[6] = '{in_len: 2, out_len: 17, wmode: 1, bpmode: 2, exp_err: 0, exp_tiles: 3, exp_last_user: 0};
        vecs[7] = '{in_len: 1, out_len: 9,  wmode: 1, bpmode: 1, exp_err: 0, exp_tiles: 2, exp_last_user: 0};

        rst                  = 1'b0;
        s_cfg_in_len         = '0;
        s_cfg_out_len        = '0;
        s_cfg_valid          = 1'b0;
        s_axis_data_tdata    = '0;
        s_axis_data_tvalid   = 1'b0;
        s_axis_weight_tdata  = '0;
        s_axis_weight_tvalid = 1'b0;
        m_axis_pe_tready     = 1'b1;
        rslt_beat            = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset while the PE-side beat is stalled with tvalid high.
        @(negedge clk);
        s_cfg_in_len  = 16'd6;
        s_cfg_out_len = 16'd8;
        s_cfg_valid   = 1'b1;
        @(negedge clk);
        s_cfg_valid          = 1'b0;
        m_axis_pe_tready     = 1'b0;
        s_axis_data_tvalid   = 1'b1;
        s_axis_weight_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_tvalid", 192'(m_axis_pe_tvalid), 192'(1));
        chk("pre_reset_busy", 192'(busy), 192'(1));
        #1 rst = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        s_axis_data_tvalid   = 1'b0;
        s_axis_weight_tvalid = 1'b0;
        m_axis_pe_tready     = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[1], 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
